// File: rtl/mips32_pkg.sv
// Shared widths and dump-engine state encoding used by mem_dump and its FIFO.
package mips32_pkg;

  localparam int unsigned DUMP_ADDR_W = 10;
  localparam int unsigned DUMP_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_DRAIN,
    ST_DONE
  } dump_state_e;

  // A new read may issue only if FIFO entries plus the read returning this
  // cycle, less any word leaving this cycle, stays below the FIFO depth of 2.
  function automatic logic dump_can_issue(input logic full, input logic empty,
                                          input logic inflight, input logic pop);
    if (inflight) return empty || (pop && !full);
    else          return !full || pop;
  endfunction

endpackage

// File: rtl/mem_dump_fifo.sv
// Two-entry FIFO holding returned read words; supports push and pop in the same cycle.
module dump_fifo #(
  parameter int unsigned W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] wdata_i,
  output logic         full_o,
  output logic         empty_o,
  output logic [W-1:0] rdata_o
);

  logic [W-1:0] mem_q [2];
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   occ_q, occ_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q ^ push_i;
    rd_ptr_d = rd_ptr_q ^ pop_i;
    occ_d    = occ_q;
    if (push_i && !pop_i)      occ_d = occ_q + 2'd1;
    else if (!push_i && pop_i) occ_d = occ_q - 2'd1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign full_o  = (occ_q == 2'd2);
  assign empty_o = (occ_q == 2'd0);
  assign rdata_o = mem_q[rd_ptr_q];

endmodule

// File: rtl/mem_dump.sv
// Streams a contiguous range of data memory out over a valid/ready port.
module mem_dump
  import mips32_pkg::*;
#(
  parameter int unsigned ADDR_W = DUMP_ADDR_W,
  parameter int unsigned DATA_W = DUMP_DATA_W
) (
  input  logic              clk_x,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   count,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  localparam int unsigned FW = DATA_W + ADDR_W + 1;
  localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

  dump_state_e       state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [ADDR_W:0]   idx_q, idx_d;
  logic              infl_q, infl_d;
  logic [ADDR_W-1:0] infl_addr_q, infl_addr_d;
  logic              infl_last_q, infl_last_d;

  logic              fifo_full, fifo_empty, pop;
  logic [FW-1:0]     head;
  logic              head_last;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_last;

  assign pop     = !fifo_empty && out_ready;
  assign rd_addr = base_q + idx_q[ADDR_W-1:0];
  assign rd_last = (idx_q == cnt_q - CNT_ONE);

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    infl_d      = 1'b0;
    infl_addr_d = infl_addr_q;
    infl_last_d = infl_last_q;
    mem_re      = 1'b0;
    mem_addr    = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          base_d  = base_addr;
          cnt_d   = count;
          idx_d   = '0;
          state_d = (count == '0) ? ST_DONE : ST_READ;
        end
      end
      ST_READ: begin
        if (dump_can_issue(fifo_full, fifo_empty, infl_q, pop)) begin
          mem_re      = 1'b1;
          mem_addr    = rd_addr;
          infl_d      = 1'b1;
          infl_addr_d = rd_addr;
          infl_last_d = rd_last;
          idx_d       = idx_q + CNT_ONE;
          if (rd_last) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (pop && head_last) state_d = ST_DONE;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Clearing infl_q on reset drops any read data still returning afterwards.
  always_ff @(posedge clk_x) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      base_q      <= '0;
      cnt_q       <= '0;
      idx_q       <= '0;
      infl_q      <= 1'b0;
      infl_addr_q <= '0;
      infl_last_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      infl_q      <= infl_d;
      infl_addr_q <= infl_addr_d;
      infl_last_q <= infl_last_d;
    end
  end

  dump_fifo #(
    .W(FW)
  ) u_fifo (
    .clk_i   (clk_x),
    .rst_ni  (rst),
    .push_i  (infl_q),
    .pop_i   (pop),
    .wdata_i ({infl_last_q, infl_addr_q, mem_rdata}),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .rdata_o (head)
  );

  assign {head_last, head_addr, head_data} = head;

  assign out_valid = !fifo_empty;
  assign out_addr  = fifo_empty ? '0 : head_addr;
  assign out_data  = fifo_empty ? '0 : head_data;
  assign out_last  = !fifo_empty && head_last;
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_mem_dump.sv
// Bench for mem_dump: stream model with per-cycle compare plus directed dumps.
module tb_mem_dump;

  localparam int unsigned AW = 10;
  localparam int unsigned DW = 32;

  logic          clk_x = 1'b0;
  logic          rst, start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   count;
  logic          mem_re;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata = '0;
  logic          out_valid, out_ready;
  logic [AW-1:0] out_addr;
  logic [DW-1:0] out_data;
  logic          out_last, busy, done;

  mem_dump #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk_x(clk_x), .rst(rst), .start(start), .base_addr(base_addr), .count(count),
    .mem_re(mem_re), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
    .out_data(out_data), .out_last(out_last), .busy(busy), .done(done)
  );

  always #5 clk_x = ~clk_x;

  int checks = 0;
  int errors = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return 32'(a) * 32'h01010101;
  endfunction

  // Memory model: one-cycle read latency, garbage when no read was issued.
  always @(posedge clk_x) mem_rdata <= mem_re ? mem_word(mem_addr) : 32'hDEADBEEF;

  int rdy_mode = 0;
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk_x);
      #1;
      out_ready = (rdy_mode == 1) ? ~out_ready : 1'b1;
    end
  end

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic          l;
  } word_t;

  word_t         exp_q[$];
  logic [AW-1:0] rd_q[$];
  logic          m_busy = 1'b0, m_done = 1'b0, m_stall = 1'b0;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_data;
  logic          s_last;
  int            issued = 0, xfers = 0;

  initial begin
    logic xfer, hl, nb, nd;
    logic [AW-1:0] a;
    @(posedge clk_x);
    forever begin
      @(negedge clk_x);
      xfer = out_valid && out_ready;
      hl   = 1'b0;
      chk("busy", busy, m_busy);
      chk("done", done, m_done);
      if (m_stall) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_addr", out_addr, s_addr);
        chk("stall_data", out_data, s_data);
        chk("stall_last", out_last, s_last);
      end
      if (out_valid) begin
        if (exp_q.size() == 0) chk("spurious_valid", out_valid, 0);
        else begin
          chk("out_addr", out_addr, exp_q[0].a);
          chk("out_data", out_data, exp_q[0].d);
          chk("out_last", out_last, exp_q[0].l);
          hl = exp_q[0].l;
          if (xfer) void'(exp_q.pop_front());
        end
      end
      if (mem_re) begin
        if (rd_q.size() == 0) chk("spurious_re", mem_re, 0);
        else begin
          chk("rd_addr", mem_addr, rd_q.pop_front());
          chk("rd_room", ((issued - xfers - (xfer ? 1 : 0)) < 2), 1);
          issued++;
        end
      end
      if (!rst) begin
        m_busy = 1'b0; m_done = 1'b0; m_stall = 1'b0;
        exp_q.delete(); rd_q.delete();
        issued = 0; xfers = 0;
      end else begin
        nb = m_done ? 1'b0 : m_busy;
        nd = xfer && hl;
        if (!m_busy && start) begin
          nb = 1'b1;
          if (count == '0) nd = 1'b1;
          else for (int unsigned i = 0; i < 32'(count); i++) begin
            a = base_addr + AW'(i);
            exp_q.push_back('{a, mem_word(a), (i == 32'(count) - 1)});
            rd_q.push_back(a);
          end
        end
        if (xfer) xfers++;
        m_stall = out_valid && !out_ready;
        s_addr = out_addr; s_data = out_data; s_last = out_last;
        m_busy = nb; m_done = nd;
      end
    end
  end

  logic [AW-1:0] cap_a[$];
  logic [DW-1:0] cap_d[$];
  logic          cap_l[$];
  int k_re, k_valid, k_last, k_done, n_x;

  // k counts cycles after the start-sampling edge (k=1 is the first READ cycle).
  task automatic dump(input logic [AW-1:0] b, input logic [AW:0] c, input int budget);
    cap_a.delete(); cap_d.delete(); cap_l.delete();
    k_re = 0; k_valid = 0; k_last = 0; k_done = 0; n_x = 0;
    @(posedge clk_x); #1;
    start = 1'b1; base_addr = b; count = c;
    @(posedge clk_x); #1;
    start = 1'b0; base_addr = AW'($urandom); count = (AW+1)'($urandom);
    for (int k = 1; k <= budget; k++) begin
      @(negedge clk_x);
      if (mem_re && k_re == 0) k_re = k;
      if (out_valid && k_valid == 0) k_valid = k;
      if (out_valid && out_ready) begin
        cap_a.push_back(out_addr); cap_d.push_back(out_data); cap_l.push_back(out_last);
        n_x++;
        if (out_last) k_last = k;
      end
      if (done) begin
        k_done = k;
        break;
      end
      @(posedge clk_x); #1;
      start = (k == 1);
      base_addr = AW'($urandom); count = (AW+1)'($urandom);
    end
    chk("dump_finished", (k_done != 0), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, nl;
    rst = 1'b0; start = 1'b0; base_addr = '0; count = '0;
    repeat (2) @(posedge clk_x);
    @(negedge clk_x);
    chk("rst_mem_re", mem_re, 0);     chk("rst_mem_addr", mem_addr, 0);
    chk("rst_out_valid", out_valid, 0); chk("rst_out_addr", out_addr, 0);
    chk("rst_out_data", out_data, 0); chk("rst_out_last", out_last, 0);
    chk("rst_busy", busy, 0);         chk("rst_done", done, 0);
    @(posedge clk_x); #1 rst = 1'b1;

    dump(10'd1, 11'd3, 50);
    chk("b1_first_re", k_re, 1);
    chk("b1_first_valid", k_valid, 3);
    chk("b1_n", n_x, 3);
    chk("b1_a0", cap_a[0], 1); chk("b1_d0", cap_d[0], 32'h01010101);
    chk("b1_a1", cap_a[1], 2); chk("b1_d1", cap_d[1], 32'h02020202);
    chk("b1_a2", cap_a[2], 3); chk("b1_d2", cap_d[2], 32'h03030303);
    chk("b1_last", {cap_l[0], cap_l[1], cap_l[2]}, 3'b001);
    chk("b1_done_lat", k_done, k_last + 1);

    dump(10'd1022, 11'd4, 50);
    chk("wrap_n", n_x, 4);
    chk("wrap_a0", cap_a[0], 1022); chk("wrap_d0", cap_d[0], 32'h020201FE);
    chk("wrap_a1", cap_a[1], 1023); chk("wrap_d1", cap_d[1], 32'h030302FF);
    chk("wrap_a2", cap_a[2], 0);    chk("wrap_d2", cap_d[2], 32'h00000000);
    chk("wrap_a3", cap_a[3], 1);    chk("wrap_d3", cap_d[3], 32'h01010101);

    rdy_mode = 1;
    dump(10'd10, 11'd3, 60);
    rdy_mode = 0;
    chk("tog_n", n_x, 3);
    chk("tog_a0", cap_a[0], 10); chk("tog_d0", cap_d[0], 32'h0A0A0A0A);
    chk("tog_a1", cap_a[1], 11); chk("tog_d1", cap_d[1], 32'h0B0B0B0B);
    chk("tog_a2", cap_a[2], 12); chk("tog_d2", cap_d[2], 32'h0C0C0C0C);

    dump(10'd7, 11'd0, 10);
    chk("zero_done_lat", k_done, 1);
    chk("zero_no_valid", k_valid, 0);
    chk("zero_no_re", k_re, 0);

    dump(10'd0, 11'd1024, 1100);
    chk("full_first_re", k_re, 1);
    chk("full_n", n_x, 1024);
    chk("full_last_cycle", k_last, 1026);
    chk("full_done", k_done, 1027);
    nl = 0;
    foreach (cap_l[i]) if (cap_l[i]) nl++;
    chk("full_one_last", nl, 1);
    chk("full_last_addr", cap_a[1023], 1023);
    chk("full_last_flag", cap_l[1023], 1);

    @(posedge clk_x); #1;
    start = 1'b1; base_addr = 10'd100; count = 11'd8;
    @(posedge clk_x); #1;
    start = 1'b0;
    n = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk_x);
      if (out_valid && out_ready) n++;
      if (n == 2) break;
    end
    chk("mid_two_xfers", n, 2);
    @(posedge clk_x); #1 rst = 1'b0;
    @(posedge clk_x); #1 rst = 1'b1;
    @(negedge clk_x);
    chk("mid_mem_re", mem_re, 0);     chk("mid_mem_addr", mem_addr, 0);
    chk("mid_out_valid", out_valid, 0); chk("mid_out_addr", out_addr, 0);
    chk("mid_out_data", out_data, 0); chk("mid_out_last", out_last, 0);
    chk("mid_busy", busy, 0);         chk("mid_done", done, 0);
    repeat (3) begin
      @(negedge clk_x);
      chk("mid_quiet", out_valid, 0);
    end

    dump(10'd5, 11'd1, 30);
    chk("one_n", n_x, 1);
    chk("one_a", cap_a[0], 5);
    chk("one_d", cap_d[0], 32'h05050505);
    chk("one_last", cap_l[0], 1);

    repeat (3) @(negedge clk_x);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
